// File: rtl/mm_pkg.sv
// Shared types and sizes for the matrix-multiply sequencer.
package mm_pkg;

    localparam int MAX_ELEMS = 18;
    localparam int DATA_W    = 4;
    localparam int DEF_RES_W = 10;
    localparam int CNT_W     = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_STREAM,
        S_WAIT,
        S_DRAIN,
        S_UNLOAD
    } state_t;

    function automatic logic [CNT_W-1:0] dim_prod(
        input logic [1:0] a,
        input logic [1:0] b
    );
        return CNT_W'(a) * CNT_W'(b);
    endfunction

endpackage

// File: rtl/mm_elem_buf.sv
// Element store: 18x4 register file, synchronous write, combinational read.
module mm_elem_buf
    import mm_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [CNT_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [CNT_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [MAX_ELEMS];

    always_ff @(posedge clk) begin
        if (we && wr_idx < CNT_W'(MAX_ELEMS))
            mem[wr_idx] <= wr_data;
    end

    assign rd_data = (rd_idx < CNT_W'(MAX_ELEMS)) ? mem[rd_idx] : '0;

endmodule

// File: rtl/mm_sequencer.sv
// Collects W and X elements, streams them into the MAC bank,
// then unloads the row_w x col_x results over a valid/ready port.
module mm_sequencer
    import mm_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int RES_W        = DEF_RES_W
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               start,
    input  logic [1:0]         row_w,
    input  logic [1:0]         col_w,
    input  logic [1:0]         row_x,
    input  logic [1:0]         col_x,
    output logic               err,
    output logic               busy,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic               mem_clear,
    output logic [DATA_W-1:0]  mem_data,
    input  logic               unload_res,
    input  logic [9*RES_W-1:0] res_bus,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RES_W-1:0]   out_data,
    output logic [3:0]         out_idx,
    output logic               out_last,
    output logic               done
);

    state_t            state;
    logic [1:0]        rw, cx;
    logic [CNT_W-1:0]  n, cnt, ui, uj;
    logic [CNT_W-1:0]  nxt_i, nxt_j;
    logic [3:0]        nxt_idx;
    logic              nxt_last;
    logic [RES_W-1:0]  nxt_data;
    logic [DATA_W-1:0] rd_data;
    logic              buf_we;
    logic [CNT_W-1:0]  rd_idx;
    logic [RES_W-1:0]  res_arr [9];

    for (genvar g = 0; g < 9; g++) begin : g_res
        assign res_arr[g] = res_bus[g*RES_W +: RES_W];
    end

    assign buf_we = (state == S_COLLECT) && in_valid && in_ready;
    assign rd_idx = (state == S_STREAM) ? cnt : '0;

    mm_elem_buf u_buf (
        .clk     (clk),
        .we      (buf_we),
        .wr_idx  (cnt),
        .wr_data (in_data),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    // Row-major walk over the i<row_w, j<col_x result grid
    always_comb begin
        nxt_i = ui;
        nxt_j = uj + CNT_W'(1);
        if (uj + CNT_W'(1) >= {3'b0, cx}) begin
            nxt_i = ui + CNT_W'(1);
            nxt_j = '0;
        end
        nxt_idx  = 4'(nxt_i * CNT_W'(3) + nxt_j);
        nxt_last = (nxt_i == {3'b0, rw} - CNT_W'(1)) &&
                   (nxt_j == {3'b0, cx} - CNT_W'(1));
        nxt_data = (nxt_idx < 4'd9) ? res_arr[nxt_idx] : '0;
    end

    always_ff @(posedge clk) begin
        err  <= 1'b0;
        done <= 1'b0;
        if (clear) begin
            state     <= S_IDLE;
            rw        <= '0;
            cx        <= '0;
            n         <= '0;
            cnt       <= '0;
            ui        <= '0;
            uj        <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            mem_clear <= 1'b1;
            mem_data  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        if (row_w != 2'd0 && col_w != 2'd0 &&
                            row_x != 2'd0 && col_x != 2'd0 &&
                            col_w == row_x) begin
                            rw       <= row_w;
                            cx       <= col_x;
                            n        <= dim_prod(row_w, col_w) +
                                        dim_prod(row_x, col_x);
                            cnt      <= '0;
                            busy     <= 1'b1;
                            in_ready <= 1'b1;
                            state    <= S_COLLECT;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    if (in_valid && in_ready) begin
                        if (cnt + CNT_W'(1) >= n) begin
                            // buf[0] is already stored; present it at once
                            in_ready  <= 1'b0;
                            mem_clear <= 1'b0;
                            mem_data  <= rd_data;
                            cnt       <= CNT_W'(1);
                            state     <= S_STREAM;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_STREAM: begin
                    if (cnt < n) begin
                        mem_data <= rd_data;
                        cnt      <= cnt + CNT_W'(1);
                    end else begin
                        mem_data <= '0;
                        cnt      <= '0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (unload_res) begin
                        cnt   <= '0;
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (cnt >= CNT_W'(DRAIN_CYCLES - 1)) begin
                        cnt       <= '0;
                        ui        <= '0;
                        uj        <= '0;
                        out_valid <= 1'b1;
                        out_data  <= res_arr[0];
                        out_idx   <= '0;
                        out_last  <= (rw == 2'd1) && (cx == 2'd1);
                        state     <= S_UNLOAD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_UNLOAD: begin
                    if (out_ready) begin
                        if (out_last) begin
                            ui        <= '0;
                            uj        <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            mem_clear <= 1'b1;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_idx   <= '0;
                            out_last  <= 1'b0;
                            state     <= S_IDLE;
                        end else begin
                            ui       <= nxt_i;
                            uj       <= nxt_j;
                            out_idx  <= nxt_idx;
                            out_data <= nxt_data;
                            out_last <= nxt_last;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mm_sequencer.sv
// Directed bench for mm_sequencer with a behavioural MAC bank model.
module tb_mm_sequencer;

    localparam int RW = 10;
    localparam int DC = 4;

    logic          clk = 1'b0;
    logic          clear = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    row_w = '0, col_w = '0, row_x = '0, col_x = '0;
    logic          err, busy, in_ready, mem_clear, out_valid;
    logic          out_last, done;
    logic          in_valid = 1'b0;
    logic [3:0]    in_data = '0;
    logic [3:0]    mem_data, out_idx;
    logic          unload_res = 1'b0;
    logic          out_ready = 1'b1;
    logic [9*RW-1:0] res_bus = '0;
    logic [RW-1:0] out_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mm_sequencer #(.DRAIN_CYCLES(DC), .RES_W(RW)) dut (
        .clk(clk), .clear(clear), .start(start),
        .row_w(row_w), .col_w(col_w), .row_x(row_x), .col_x(col_x),
        .err(err), .busy(busy),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_clear(mem_clear), .mem_data(mem_data),
        .unload_res(unload_res), .res_bus(res_bus),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .done(done)
    );

    // bank model and output monitor state
    int b_rw, b_cw, b_cx, bank_n, bank_k, bank_dly;
    logic [3:0] cap [18];
    logic [3:0] el [18];
    int rec_n, done_cnt, err_cnt, lat;
    logic lat_done;
    logic [RW-1:0] rec_data [16];
    logic [3:0] rec_idx [16];
    logic rec_last [16];
    int stall_en, stall_left, stall_seen, stall_bad;
    logic prev_stall = 1'b0;
    logic [RW-1:0] h_data;
    logic [3:0] h_idx;
    logic h_last;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
        if (unload_res && out_valid === 1'b0 && !lat_done) lat++;
        if (out_valid === 1'b1) lat_done = 1'b1;
        if (prev_stall) begin
            stall_seen++;
            if (out_data !== h_data || out_idx !== h_idx ||
                out_last !== h_last || out_valid !== 1'b1)
                stall_bad++;
        end
        if (stall_en != 0 && rec_n == 1 && stall_left > 0 &&
            out_valid === 1'b1) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = 1'b1;
        end
        if (out_valid === 1'b1 && out_ready && rec_n < 16) begin
            rec_data[rec_n] = out_data;
            rec_idx[rec_n]  = out_idx;
            rec_last[rec_n] = out_last;
            rec_n++;
        end
        h_data = out_data;
        h_idx  = out_idx;
        h_last = out_last;
        prev_stall = (out_valid === 1'b1) && !out_ready;
        // bank: capture the stream, then compute W*X and raise done
        if (mem_clear !== 1'b0) begin
            bank_k = 0;
            bank_dly = 0;
            unload_res = 1'b0;
        end else if (bank_k < bank_n) begin
            cap[bank_k] = mem_data;
            bank_k++;
        end else if (!unload_res) begin
            bank_dly++;
            if (bank_dly == 3) begin
                res_bus = '0;
                for (int i = 0; i < b_rw; i++)
                    for (int j = 0; j < b_cx; j++) begin
                        int acc;
                        acc = 0;
                        for (int k = 0; k < b_cw; k++)
                            acc += int'(cap[i*b_cw+k]) *
                                   int'(cap[b_rw*b_cw + k*b_cx + j]);
                        res_bus[(i*3+j)*RW +: RW] = RW'(acc);
                    end
                unload_res = 1'b1;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic new_job();
        rec_n = 0; done_cnt = 0; err_cnt = 0;
        lat = 0; lat_done = 1'b0;
        stall_en = 0; stall_left = 0;
        stall_seen = 0; stall_bad = 0;
    endtask

    task automatic do_start(input int a, input int b,
                            input int c, input int d);
        b_rw = a; b_cw = b; b_cx = d;
        bank_n = a*b + c*d;
        row_w = 2'(a); col_w = 2'(b); row_x = 2'(c); col_x = 2'(d);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input int n);
        for (int e = 0; e < n; e++) begin
            int g;
            in_valid = 1'b1;
            in_data = el[e];
            g = 0;
            while (in_ready !== 1'b1 && g < 20) begin
                step();
                g++;
            end
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL feed_ready elem=%0d in_ready=%b required 1",
                         e, in_ready);
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int g;
        g = 0;
        while (done_cnt < target && g < 400) begin
            step();
            g++;
        end
        checks++;
        if (done_cnt != target) begin
            errors++;
            $display("FAIL done_wait got=%0d required %0d", done_cnt, target);
        end
    endtask

    task automatic test_reset();
        clear = 1'b1;
        step();
        step();
        clear = 1'b0;
        checks++;
        if ({busy, err, done, in_ready, out_valid, out_last, mem_clear} !==
            7'b0000001) begin
            errors++;
            $display("FAIL reset_flags got=%b required 0000001",
                     {busy, err, done, in_ready, out_valid, out_last, mem_clear});
        end
        checks++;
        if (mem_data !== 4'd0 || out_idx !== 4'd0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_data mem=%0d idx=%0d data=%0d required 0",
                     mem_data, out_idx, out_data);
        end
    endtask

    task automatic test_basic();
        int ecap[8];
        int ed[4];
        int ei[4];
        ecap = '{1, 2, 3, 4, 1, 0, 0, 1};
        ed = '{1, 2, 3, 4};
        ei = '{0, 1, 3, 4};
        new_job();
        el[0] = 1; el[1] = 2; el[2] = 3; el[3] = 4;
        el[4] = 1; el[5] = 0; el[6] = 0; el[7] = 1;
        do_start(2, 2, 2, 2);
        feed(8);
        wait_done(1);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (cap[k] !== 4'(ecap[k])) begin
                errors++;
                $display("FAIL basic_stream k=%0d got=%0d required %0d",
                         k, cap[k], ecap[k]);
            end
        end
        checks++;
        if (rec_n != 4) begin
            errors++;
            $display("FAIL basic_count got=%0d required 4", rec_n);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rec_data[k] !== RW'(ed[k]) || rec_idx[k] !== 4'(ei[k]) ||
                rec_last[k] !== (k == 3)) begin
                errors++;
                $display("FAIL basic_res k=%0d got=%0d/%0d/%b required %0d/%0d/%b",
                         k, rec_data[k], rec_idx[k], rec_last[k],
                         ed[k], ei[k], k == 3);
            end
        end
        checks++;
        if (lat != DC) begin
            errors++;
            $display("FAIL drain_len got=%0d required %0d", lat, DC);
        end
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || mem_clear !== 1'b1) begin
            errors++;
            $display("FAIL basic_idle busy=%b done=%b mc=%b required 0/0/1",
                     busy, done, mem_clear);
        end
    endtask

    task automatic test_full();
        new_job();
        for (int k = 0; k < 18; k++) el[k] = 4'd2;
        do_start(3, 3, 3, 3);
        feed(18);
        wait_done(1);
        checks++;
        if (rec_n != 9) begin
            errors++;
            $display("FAIL full_count got=%0d required 9", rec_n);
        end
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (rec_data[k] !== RW'(12) || rec_idx[k] !== 4'(k) ||
                rec_last[k] !== (k == 8)) begin
                errors++;
                $display("FAIL full_res k=%0d got=%0d/%0d/%b required 12/%0d/%b",
                         k, rec_data[k], rec_idx[k], rec_last[k], k, k == 8);
            end
        end
    endtask

    task automatic test_err();
        new_job();
        row_w = 2'd1; col_w = 2'd2; row_x = 2'd3; col_x = 2'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse err=%b busy=%b rdy=%b required 1/0/0",
                     err, busy, in_ready);
        end
        step();
        checks++;
        if (err !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL err_after err=%b busy=%b rdy=%b required 0/0/0",
                     err, busy, in_ready);
        end
        row_w = 2'd0; col_w = 2'd1; row_x = 2'd1; col_x = 2'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if (err_cnt != 2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_zero pulses=%0d busy=%b required 2/0",
                     err_cnt, busy);
        end
    endtask

    task automatic test_stall();
        int ed[4];
        int ei[4];
        ed = '{19, 22, 43, 50};
        ei = '{0, 1, 3, 4};
        new_job();
        stall_en = 1;
        stall_left = 5;
        el[0] = 1; el[1] = 2; el[2] = 3; el[3] = 4;
        el[4] = 5; el[5] = 6; el[6] = 7; el[7] = 8;
        do_start(2, 2, 2, 2);
        feed(8);
        wait_done(1);
        checks++;
        if (stall_seen != 5 || stall_bad != 0) begin
            errors++;
            $display("FAIL stall_hold seen=%0d bad=%0d required 5/0",
                     stall_seen, stall_bad);
        end
        checks++;
        if (rec_n != 4) begin
            errors++;
            $display("FAIL stall_count got=%0d required 4", rec_n);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rec_data[k] !== RW'(ed[k]) || rec_idx[k] !== 4'(ei[k]) ||
                rec_last[k] !== (k == 3)) begin
                errors++;
                $display("FAIL stall_res k=%0d got=%0d/%0d required %0d/%0d",
                         k, rec_data[k], rec_idx[k], ed[k], ei[k]);
            end
        end
    endtask

    task automatic test_clear_stream();
        int ed[4];
        ed = '{8, 5, 20, 13};
        new_job();
        for (int k = 0; k < 18; k++) el[k] = 4'd1;
        do_start(3, 3, 3, 3);
        feed(18);
        step();
        step();
        checks++;
        if (mem_data !== 4'd1 || mem_clear !== 1'b0) begin
            errors++;
            $display("FAIL clr_pre mem=%0d mc=%b required 1/0",
                     mem_data, mem_clear);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if (busy !== 1'b0 || mem_clear !== 1'b1 || mem_data !== 4'd0 ||
            in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clr_state busy=%b mc=%b mem=%0d rdy=%b ov=%b",
                     busy, mem_clear, mem_data, in_ready, out_valid);
        end
        new_job();
        el[0] = 1; el[1] = 2; el[2] = 3; el[3] = 4;
        el[4] = 4; el[5] = 3; el[6] = 2; el[7] = 1;
        do_start(2, 2, 2, 2);
        feed(8);
        wait_done(1);
        checks++;
        if (rec_n != 4) begin
            errors++;
            $display("FAIL clr_count got=%0d required 4", rec_n);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rec_data[k] !== RW'(ed[k])) begin
                errors++;
                $display("FAIL clr_res k=%0d got=%0d required %0d",
                         k, rec_data[k], ed[k]);
            end
        end
    endtask

    task automatic test_ignore();
        int g;
        int ed[4];
        int ei[4];
        ed = '{8, 10, 12, 15};
        ei = '{0, 1, 3, 4};
        new_job();
        in_valid = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready got=%b required 0", in_ready);
        end
        in_valid = 1'b0;
        el[0] = 2; el[1] = 3; el[2] = 4; el[3] = 5;
        do_start(2, 1, 1, 2);
        start = 1'b1;
        step();
        start = 1'b0;
        feed(4);
        g = 0;
        while (bank_k < bank_n && g < 50) begin
            step();
            g++;
        end
        step();
        start = 1'b1;
        in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready rdy=%b busy=%b required 0/1",
                     in_ready, busy);
        end
        step();
        start = 1'b0;
        in_valid = 1'b0;
        wait_done(1);
        for (int k = 0; k < 10; k++) step();
        checks++;
        if (done_cnt != 1 || err_cnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ign_once done=%0d err=%0d busy=%b required 1/0/0",
                     done_cnt, err_cnt, busy);
        end
        checks++;
        if (rec_n != 4) begin
            errors++;
            $display("FAIL ign_count got=%0d required 4", rec_n);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rec_data[k] !== RW'(ed[k]) || rec_idx[k] !== 4'(ei[k])) begin
                errors++;
                $display("FAIL ign_res k=%0d got=%0d/%0d required %0d/%0d",
                         k, rec_data[k], rec_idx[k], ed[k], ei[k]);
            end
        end
    endtask

    task automatic test_edges();
        new_job();
        el[0] = 5; el[1] = 3;
        do_start(1, 1, 1, 1);
        feed(2);
        wait_done(1);
        checks++;
        if (rec_n != 1 || rec_data[0] !== RW'(15) || rec_idx[0] !== 4'd0 ||
            rec_last[0] !== 1'b1) begin
            errors++;
            $display("FAIL one_res n=%0d got=%0d/%0d/%b required 1 15/0/1",
                     rec_n, rec_data[0], rec_idx[0], rec_last[0]);
        end
        new_job();
        el[0] = 3; el[1] = 1; el[2] = 2; el[3] = 3;
        do_start(1, 1, 1, 3);
        feed(4);
        wait_done(1);
        checks++;
        if (rec_n != 3) begin
            errors++;
            $display("FAIL row_count got=%0d required 3", rec_n);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rec_data[k] !== RW'(3*(k+1)) || rec_idx[k] !== 4'(k) ||
                rec_last[k] !== (k == 2)) begin
                errors++;
                $display("FAIL row_res k=%0d got=%0d/%0d/%b required %0d/%0d/%b",
                         k, rec_data[k], rec_idx[k], rec_last[k],
                         3*(k+1), k, k == 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_err();
        test_stall();
        test_clear_stream();
        test_ignore();
        test_edges();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
